i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C master engine among NUM_REQ on-chip requesters.
- Each requester posts a single-byte transaction (7-bit slave address, R/W, write byte) and holds it until completion.
- The arbiter grants round-robin, launches the engine with a start pulse, waits for completion, then returns read data and NACK status to the winner.
- Sits between requester logic (sensor pollers, config loaders) and the I2C master that drives i2c_sda/i2c_scl.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, engine watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until the matching done pulse.
- req_addr  in  7*NUM_REQ  slave address, requester i at [7i+6:7i].
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_wdata  in  8*NUM_REQ  write byte, requester i at [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  8  read byte, valid in the done cycle and held until the next done.
- nack  out  1  slave NACK or timeout flag, valid with done.
- m_start  out  1  one-cycle launch pulse to the engine.
- m_addr  out  7  latched address to the engine.
- m_rw  out  1  latched R/W to the engine.
- m_wdata  out  8  latched write byte to the engine.
- m_busy  in  1  engine busy.
- m_done  in  1  engine completion pulse.
- m_rdata  in  8  engine read byte, valid with m_done.
- m_nack  in  1  engine NACK flag, valid with m_done.

Behaviour:
- Reset values:
  - gnt, done, rdata, nack, m_start, m_addr, m_rw, m_wdata = 0.
  - state = IDLE; round-robin pointer = 0.
- States:
  - IDLE: if any req is high and m_busy is low, select the first requester at or after the pointer (wrapping NUM_REQ-1 -> 0). Register gnt, m_addr, m_rw and m_wdata from that requester, then go to ISSUE. If m_busy is high, do not grant.
  - ISSUE: assert m_start for exactly one cycle, then go to WAIT.
  - WAIT: hold gnt. When m_done is seen, latch m_rdata into rdata and m_nack into nack, then go to RETIRE.
  - RETIRE: pulse done for the granted index, clear gnt, set pointer = granted index + 1 (wrapping), then go to IDLE.
- Latency:
  - Request to gnt: 1 cycle.
  - gnt to m_start: 1 cycle.
  - m_done to done: 1 cycle.
  - Minimum inter-transaction gap is 1 IDLE cycle.
- Handshake rules:
  - Inputs are sampled only in IDLE; later changes to req_* are ignored.
  - If a requester drops req mid-transaction, the transaction still completes and done still pulses.
  - rdata is updated on write transactions too (engine value passed through). Requesters ignore it for writes.
- Boundary conditions:
  - m_done in the same cycle as m_start is ignored; completion counts only in WAIT.
  - m_done outside WAIT is ignored.
  - Single requester asserting continuously is re-granted every transaction.
  - All NUM_REQ requesting: service order is strictly rotating and no requester waits more than NUM_REQ-1 transactions.
  - Reset mid-transaction returns immediately to the reset values. The engine is not aborted; a following m_done is ignored.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without m_done forces RETIRE with nack = 1 and rdata = 0.
  - Counter clears on entry to WAIT.
- Undefined: no counter; WAIT is unbounded.

Decomposition:
- Shared package i2c_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, RETIRE);
  - I2C_ADDR_W = 7 and I2C_DATA_W = 8.
- Sub-module rr_pick: combinational round-robin picker with inputs (req vector, pointer) and outputs (one-hot winner, winner index, any-valid).

Test Plan:
- Single write: req[1] with addr 0x50, rw 0, wdata 0xA5 -> gnt = 0010 next cycle; m_start 1 cycle later with m_addr 0x50, m_wdata 0xA5; m_done + m_nack 0 -> done[1] 1 cycle later, nack 0.
- Read data return: req[2] with rw 1; m_done with m_rdata 0x3C -> rdata = 0x3C with done[2]; rdata holds 0x3C afterwards.
- Fairness: req = 1111 held continuously, pointer 0 -> grant order 0,1,2,3,0; each done is followed by a 1-cycle gap.
- NACK propagation: m_nack = 1 with m_done -> nack = 1 on done; the next requester is still granted normally.
- Reset mid-WAIT: assert rst while gnt = 0100 -> all outputs 0 and pointer 0; a subsequent m_done produces no done.
- Timeout (with I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): no m_done -> done 16 cycles after entering WAIT (plus the RETIRE cycle), nack = 1, rdata = 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM state encoding and I2C field widths.
package i2c_arb_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RETIRE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     win_oh,
   output logic [IDX_W-1:0] win_idx,
   output logic             any_vld
);

   always_comb begin
      win_idx = '0;
      any_vld = |req;
      // scan from the farthest offset back to ptr so the nearest hit is written last
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) win_idx = IDX_W'((int'(ptr) + k) % N);
      end
      win_oh = any_vld ? (N'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master among NUM_REQ requesters.
// Optional engine watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
//   state     | meaning
//   ST_IDLE   | wait for a request while the engine is free, latch the winner
//   ST_ISSUE  | launch the engine (m_start registered, visible next cycle)
//   ST_WAIT   | wait for m_done (or watchdog expiry)
//   ST_RETIRE | done pulse to the winner, advance pointer
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [NUM_REQ-1:0]           req_rw,
   input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           done,
   output logic [I2C_DATA_W-1:0]        rdata,
   output logic                         nack,
   output logic                         m_start,
   output logic [I2C_ADDR_W-1:0]        m_addr,
   output logic                         m_rw,
   output logic [I2C_DATA_W-1:0]        m_wdata,
   input  logic                         m_busy,
   input  logic                         m_done,
   input  logic [I2C_DATA_W-1:0]        m_rdata,
   input  logic                         m_nack
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("i2c_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   arb_state_t              state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic [NUM_REQ-1:0]      done_q, done_d;
   logic [I2C_DATA_W-1:0]   rdata_q, rdata_d;
   logic                    nack_q, nack_d;
   logic                    m_start_q, m_start_d;
   logic [I2C_ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic                    m_rw_q, m_rw_d;
   logic [I2C_DATA_W-1:0]   m_wdata_q, m_wdata_d;

   logic [NUM_REQ-1:0]      win_oh;
   logic [IDX_W-1:0]        win_idx;
   logic                    any_vld;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
`endif

   rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .any_vld (any_vld)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      rdata_d   = rdata_q;
      nack_d    = nack_q;
      m_start_d = 1'b0;
      m_addr_d  = m_addr_q;
      m_rw_d    = m_rw_q;
      m_wdata_d = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_vld && !m_busy) begin
               gnt_d     = win_oh;
               idx_d     = win_idx;
               m_addr_d  = req_addr[int'(win_idx)*I2C_ADDR_W +: I2C_ADDR_W];
               m_rw_d    = req_rw[win_idx];
               m_wdata_d = req_wdata[int'(win_idx)*I2C_DATA_W +: I2C_DATA_W];
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            m_start_d = 1'b1;
            state_d   = ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_d = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
         end
         ST_WAIT: begin
            // a completion coincident with the start pulse belongs to nobody
            if (m_done && !m_start_q) begin
               rdata_d = m_rdata;
               nack_d  = m_nack;
               done_d  = gnt_q;
               state_d = ST_RETIRE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == '0) begin
               rdata_d = '0;
               nack_d  = 1'b1;
               done_d  = gnt_q;
               state_d = ST_RETIRE;
            end else begin
               tmo_cnt_d = tmo_cnt_q - 1'b1;
            end
`endif
         end
         ST_RETIRE: begin
            gnt_d   = '0;
            ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         nack_q    <= 1'b0;
         m_start_q <= 1'b0;
         m_addr_q  <= '0;
         m_rw_q    <= 1'b0;
         m_wdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         tmo_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         nack_q    <= nack_d;
         m_start_q <= m_start_d;
         m_addr_q  <= m_addr_d;
         m_rw_q    <= m_rw_d;
         m_wdata_q <= m_wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rdata   = rdata_q;
   assign nack    = nack_q;
   assign m_start = m_start_q;
   assign m_addr  = m_addr_q;
   assign m_rw    = m_rw_q;
   assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed vector table, hand sequences, randomized traffic.
module tb_i2c_bus_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, req_rw, gnt, done;
   logic [7*N-1:0] req_addr;
   logic [8*N-1:0] req_wdata;
   logic [7:0]     rdata, m_wdata, m_rdata;
   logic [6:0]     m_addr;
   logic           nack, m_start, m_rw, m_busy, m_done, m_nack;

   logic [6:0]     a_addr [N];
   logic [7:0]     a_wd   [N];

   int total = 0;
   int bad   = 0;
   int mdl_ptr = 0;

   always #5 clk = ~clk;

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         req_addr[7*i +: 7]  = a_addr[i];
         req_wdata[8*i +: 8] = a_wd[i];
      end
   end

   i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .nack(nack),
      .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
      .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // reference: first requester at or after the pointer in rotating order
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // One full transaction starting from IDLE with req already driven.
   task automatic txn(input int exp_idx, input bit drop, input logic [7:0] rd,
                      input bit nk, input int dly);
      logic [N-1:0] oh;
      oh = N'(1) << exp_idx;
      tick;
      chk("gnt", gnt, oh);
      chk("m_start_early", m_start, 0);
      if (drop) req = '0;
      tick;
      chk("m_start", m_start, 1);
      chk("m_addr", m_addr, a_addr[exp_idx]);
      chk("m_rw", m_rw, req_rw[exp_idx]);
      chk("m_wdata", m_wdata, a_wd[exp_idx]);
      m_done = 1'b1; m_rdata = 8'hEE; m_nack = 1'b1;
      tick;
      m_done = 1'b0;
      chk("m_start_pulse", m_start, 0);
      chk("done_on_start", done, 0);
      for (int i = 0; i < dly; i++) begin
         tick;
         chk("done_wait", done, 0);
      end
      m_done = 1'b1; m_rdata = rd; m_nack = nk;
      tick;
      m_done = 1'b0; m_rdata = 8'h00; m_nack = 1'b0;
      chk("done", done, oh);
      chk("rdata", rdata, rd);
      chk("nack", nack, nk);
      chk("gnt_hold", gnt, oh);
      tick;
      chk("done_pulse", done, 0);
      chk("gnt_clr", gnt, 0);
      chk("rdata_hold", rdata, rd);
      mdl_ptr = (exp_idx + 1) % N;
   endtask

   typedef struct {
      logic [N-1:0] rq;
      bit           drop;
      logic [7:0]   rd;
      bit           nk;
      int           dly;
      int           exp_idx;
   } vec_t;

   vec_t vt [14];

   initial begin
      vt[0]  = '{4'b0010, 1'b0, 8'h00, 1'b0, 2, 1};
      vt[1]  = '{4'b0100, 1'b0, 8'h3C, 1'b0, 1, 2};
      vt[2]  = '{4'b1000, 1'b0, 8'h5A, 1'b0, 0, 3};
      vt[3]  = '{4'b1111, 1'b0, 8'h01, 1'b0, 0, 0};
      vt[4]  = '{4'b1111, 1'b0, 8'h02, 1'b0, 1, 1};
      vt[5]  = '{4'b1111, 1'b0, 8'h03, 1'b0, 0, 2};
      vt[6]  = '{4'b1111, 1'b0, 8'h04, 1'b0, 3, 3};
      vt[7]  = '{4'b1111, 1'b0, 8'h05, 1'b0, 0, 0};
      vt[8]  = '{4'b0011, 1'b0, 8'h77, 1'b1, 2, 1};
      vt[9]  = '{4'b0011, 1'b0, 8'h10, 1'b0, 0, 0};
      vt[10] = '{4'b0001, 1'b1, 8'h20, 1'b0, 1, 0};
      vt[11] = '{4'b0001, 1'b0, 8'h21, 1'b0, 0, 0};
      vt[12] = '{4'b0001, 1'b0, 8'h22, 1'b1, 0, 0};
      vt[13] = '{4'b1001, 1'b0, 8'h23, 1'b0, 1, 3};

      a_addr = '{7'h10, 7'h50, 7'h2A, 7'h7F};
      a_wd   = '{8'h11, 8'hA5, 8'h33, 8'h44};
      req_rw = 4'b1100;
      req = '0; m_busy = 1'b0; m_done = 1'b0; m_rdata = '0; m_nack = 1'b0;
      rst = 1'b1;
      tick; tick;
      chk("rst_outs", {gnt, done, rdata, nack, m_start, m_addr, m_rw, m_wdata}, 0);
      rst = 1'b0;
      tick;
      chk("idle_gnt", gnt, 0);

      for (int i = 0; i < 14; i++) begin
         req = vt[i].rq;
         txn(vt[i].exp_idx, vt[i].drop, vt[i].rd, vt[i].nk, vt[i].dly);
      end

      // engine busy blocks granting
      m_busy = 1'b1;
      req = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("busy_no_gnt", gnt, 0);
      end
      m_busy = 1'b0;
      txn(2, 1'b0, 8'h3C, 1'b0, 0);

      // reset while waiting on the engine
      req = 4'b0100;
      tick;
      chk("pre_rst_gnt", gnt, 4'b0100);
      tick; tick;
      rst = 1'b1;
      #2;
      chk("rst_mid_outs", {gnt, done, rdata, nack, m_start, m_addr, m_rw, m_wdata}, 0);
      tick;
      rst = 1'b0;
      req = '0;
      mdl_ptr = 0;
      m_done = 1'b1; m_rdata = 8'h99;
      tick;
      m_done = 1'b0; m_rdata = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("stale_done", done, 0);
      end
      req = 4'b1111;
      txn(pick(req, mdl_ptr), 1'b0, 8'h42, 1'b0, 0);

      // randomized traffic against the rotating-pointer model
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++) begin
            a_addr[i] = 7'($urandom);
            a_wd[i]   = 8'($urandom);
         end
         req_rw = 4'($urandom);
         req    = 4'($urandom_range(1, 15));
         txn(pick(req, mdl_ptr), 1'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 4));
      end

`ifdef I2C_ARB_TIMEOUT_EN
      req = 4'b0001;
      tick;
      chk("tmo_gnt", gnt, 4'b0001);
      req = '0;
      tick;
      chk("tmo_start", m_start, 1);
      for (int i = 0; i < 15; i++) begin
         tick;
         chk("tmo_no_done", done, 0);
      end
      tick;
      chk("tmo_done", done, 4'b0001);
      chk("tmo_nack", nack, 1);
      chk("tmo_rdata", rdata, 0);
      tick;
      chk("tmo_gnt_clr", gnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
